// File: rtl/wb_skid_stage.sv
`default_nettype none
// ============================================================================
// Module      : wb_skid_stage
// Description : Writeback pipeline stage with a valid/ready handshake and a
//               two-entry skid buffer (main + skid). Every output, including
//               in_ready, comes straight from a flop. Synchronous flush.
//               Optional retired-write counter enabled by the macro
//               WB_STAGE_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_skid_stage #(
  parameter int XLEN  = 64,
  parameter int RA_W  = 5,
  parameter int CNT_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_result,
  input  logic [RA_W-1:0] in_rd_addr,
  input  logic            in_rd_we,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [RA_W-1:0] out_rd_addr,
  output logic            out_rd_we
`ifdef WB_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0] retire_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic            r_in_ready;
  logic            r_out_valid;
  logic            r_out_we;

  logic [XLEN-1:0] r_main_result;
  logic [RA_W-1:0] r_main_rd_addr;
  logic            r_main_we;

  logic [XLEN-1:0] r_skid_result;
  logic [RA_W-1:0] r_skid_rd_addr;
  logic            r_skid_we;

  logic            w_in_fire;
  logic            w_out_fire;
  logic            w_load_main_in;
  logic            w_load_main_skid;
  logic            w_load_skid_in;
  logic            w_main_we_nxt;
  logic            w_out_valid_nxt;
  logic            w_in_ready_nxt;

  assign w_in_fire  = in_valid & r_in_ready;
  assign w_out_fire = r_out_valid & out_ready;

  // Next-state and payload-steering decisions; flush overrides everything.
  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid_in   = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_in_fire) begin
          w_state_nxt    = ST_ONE;
          w_load_main_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_in_fire && w_out_fire) begin
          w_load_main_in = 1'b1;
        end else if (w_in_fire) begin
          w_state_nxt    = ST_TWO;
          w_load_skid_in = 1'b1;
        end else if (w_out_fire) begin
          w_state_nxt    = ST_EMPTY;
        end
      end
      ST_TWO: begin
        // in_ready is low here, so only the drain path matters.
        if (w_out_fire) begin
          w_state_nxt      = ST_ONE;
          w_load_main_skid = 1'b1;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
    if (flush) begin
      w_state_nxt      = ST_EMPTY;
      w_load_main_in   = 1'b0;
      w_load_main_skid = 1'b0;
      w_load_skid_in   = 1'b0;
    end
  end

  // Registered handshake outputs are precomputed from the next state.
  always_comb begin
    w_out_valid_nxt = (w_state_nxt != ST_EMPTY);
    w_in_ready_nxt  = (w_state_nxt != ST_TWO);
    w_main_we_nxt   = r_main_we;
    if (w_load_main_in) begin
      w_main_we_nxt = in_rd_we;
    end else if (w_load_main_skid) begin
      w_main_we_nxt = r_skid_we;
    end
  end

  // State and handshake flops; reset empties the stage immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_we    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_we    <= w_main_we_nxt & w_out_valid_nxt;
    end
  end

  // Main payload register: loaded from the input or promoted from the skid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main_result  <= '0;
      r_main_rd_addr <= '0;
      r_main_we      <= 1'b0;
    end else if (w_load_main_in) begin
      r_main_result  <= in_result;
      r_main_rd_addr <= in_rd_addr;
      r_main_we      <= in_rd_we;
    end else if (w_load_main_skid) begin
      r_main_result  <= r_skid_result;
      r_main_rd_addr <= r_skid_rd_addr;
      r_main_we      <= r_skid_we;
    end
  end

  // Skid payload register: captures the input on the first stall cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_skid_result  <= '0;
      r_skid_rd_addr <= '0;
      r_skid_we      <= 1'b0;
    end else if (w_load_skid_in) begin
      r_skid_result  <= in_result;
      r_skid_rd_addr <= in_rd_addr;
      r_skid_we      <= in_rd_we;
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign out_result  = r_main_result;
  assign out_rd_addr = r_main_rd_addr;
  assign out_rd_we   = r_out_we;

`ifdef WB_STAGE_PERF_EN
  logic [CNT_W-1:0] r_retire_cnt;

  // Count retired writes; an out_fire in a flush cycle was already sampled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_retire_cnt <= '0;
    end else if (w_out_fire && r_out_we) begin
      r_retire_cnt <= r_retire_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign retire_cnt = r_retire_cnt;
`else
  localparam int c_unused_cnt_w = CNT_W;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_skid_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_skid_stage
// Description : Scoreboard bench for wb_skid_stage. Accepted inputs push the
//               expected writeback into a queue; a monitor pops and compares
//               on every output handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_skid_stage;

  typedef struct packed {
    logic [63:0] res;
    logic [4:0]  rd;
    logic        we;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_result = '0;
  logic [4:0]  in_rd_addr = '0;
  logic        in_rd_we = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_result;
  logic [4:0]  out_rd_addr;
  logic        out_rd_we;
`ifdef WB_STAGE_PERF_EN
  logic [3:0]  retire_cnt;
`endif

  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];

  wb_skid_stage #(.XLEN(64), .RA_W(5), .CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_result  (in_result),
    .in_rd_addr (in_rd_addr),
    .in_rd_we   (in_rd_we),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_rd_addr(out_rd_addr),
    .out_rd_we  (out_rd_we)
`ifdef WB_STAGE_PERF_EN
    ,
    .retire_cnt (retire_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compare every output handshake with the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual=0x%0h expected=none", out_result);
        end else begin
          e = exp_q.pop_front();
          check("out_result", out_result, e.res);
          check("out_rd_addr", 64'(out_rd_addr), 64'(e.rd));
          check("out_rd_we", 64'(out_rd_we), 64'(e.we));
        end
      end
    end
  end

  // Drive one result, waiting (bounded) for in_ready; push it once accepted.
  task automatic send(input logic [63:0] d, input logic [4:0] rd, input logic we);
    int n = 0;
    in_valid   = 1'b1;
    in_result  = d;
    in_rd_addr = rd;
    in_rd_we   = we;
    while (!in_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=in_ready_low expected=in_ready_high");
    end else begin
      @(posedge clk);
      exp_q.push_back('{res: d, rd: rd, we: we});
      #1;
    end
    in_valid = 1'b0;
  endtask

  // Wait (bounded) until every expected entry has been observed.
  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    // Reset state
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_result", out_result, 64'd0);
    check("rst_out_rd_addr", 64'(out_rd_addr), 64'd0);
    check("rst_out_rd_we", 64'(out_rd_we), 64'd0);

    // Streaming at full rate
    out_ready = 1'b1;
    send(64'h11, 5'd1, 1'b1);
    check("stream_latency_valid", 64'(out_valid), 64'd1);
    check("stream_latency_data", out_result, 64'h11);
    check("stream_in_ready_1", 64'(in_ready), 64'd1);
    send(64'h22, 5'd2, 1'b1);
    check("stream_in_ready_2", 64'(in_ready), 64'd1);
    send(64'h33, 5'd3, 1'b1);
    check("stream_in_ready_3", 64'(in_ready), 64'd1);
    drain();
    @(posedge clk); #1;
    check("stream_empty_valid", 64'(out_valid), 64'd0);
    check("stream_empty_we", 64'(out_rd_we), 64'd0);

    // Backpressure fills the skid
    out_ready = 1'b0;
    send(64'hA, 5'd10, 1'b1);
    check("bp_in_ready_one", 64'(in_ready), 64'd1);
    send(64'hB, 5'd11, 1'b0);
    check("bp_in_ready_two", 64'(in_ready), 64'd0);
    check("bp_out_valid", 64'(out_valid), 64'd1);
    check("bp_head_data", out_result, 64'hA);
    @(posedge clk); #1;
    check("bp_hold_data", out_result, 64'hA);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_in_ready_rise", 64'(in_ready), 64'd1);
    check("bp_second_data", out_result, 64'hB);
    drain();

    // Flush while holding two entries, with an input offered
    out_ready = 1'b0;
    send(64'hD1, 5'd4, 1'b1);
    send(64'hD2, 5'd5, 1'b1);
    flush = 1'b1; in_valid = 1'b1; in_result = 64'hC; in_rd_addr = 5'd6; in_rd_we = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    check("flush2_out_valid", 64'(out_valid), 64'd0);
    check("flush2_out_we", 64'(out_rd_we), 64'd0);
    check("flush2_in_ready", 64'(in_ready), 64'd1);

    // Flush in ONE with an input that would otherwise be accepted
    send(64'hE1, 5'd7, 1'b1);
    flush = 1'b1; in_valid = 1'b1; in_result = 64'hC; in_rd_addr = 5'd8; in_rd_we = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    check("flush1_out_valid", 64'(out_valid), 64'd0);
    check("flush1_out_we", 64'(out_rd_we), 64'd0);
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("flush_nothing_emerges", 64'(out_valid), 64'd0);

    // Asynchronous reset while full
    out_ready = 1'b0;
    send(64'hF1, 5'd9, 1'b1);
    send(64'hF2, 5'd12, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_out_result", out_result, 64'd0);
    check("arst_out_rd_addr", 64'(out_rd_addr), 64'd0);
    check("arst_out_rd_we", 64'(out_rd_we), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    exp_q.delete();
    #2 rst = 1'b0;
    @(posedge clk); #1;
    check("arst_stays_empty", 64'(out_valid), 64'd0);

`ifdef WB_STAGE_PERF_EN
    // 17 writes plus 3 non-writes with a 4-bit counter wrap to 1
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      send(64'(i + 100), 5'(i), (i < 17) ? 1'b1 : 1'b0);
    end
    drain();
    @(posedge clk); #1;
    check("retire_cnt_wrap", 64'(retire_cnt), 64'd1);
`endif

    repeat (2) @(posedge clk);
    #1;
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_skid_stage.md
# wb_skid_stage

Parametrised writeback pipeline stage that replaces the plain stall-gated MEM/WB register with a valid/ready handshake backed by a two-entry skid buffer. It sits between the memory stage and the register-file write port. It accepts one result per cycle and holds results under downstream backpressure without losing data. All outputs and `in_ready` are registered, so no combinational path crosses the stage. A synchronous flush and an optional retired-write counter are provided.

## Interface
- `XLEN`, 64, result data width
- `RA_W`, 5, register address width
- `CNT_W`, 32, retired-write counter width (used only with `WB_STAGE_PERF_EN`)

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `flush` in 1: synchronous pipeline flush
- `in_valid` in 1: upstream result valid
- `in_ready` out 1: stage can accept a result (registered)
- `in_result` in XLEN: result data
- `in_rd_addr` in RA_W: destination register
- `in_rd_we` in 1: register write enable
- `out_valid` out 1: output holds a result
- `out_ready` in 1: write port accepts the result
- `out_result` out XLEN: result to the register file
- `out_rd_addr` out RA_W: destination register to the register file
- `out_rd_we` out 1: write enable to the register file, already qualified with `out_valid`
- `retire_cnt` out CNT_W: count of retired writes (present only with `WB_STAGE_PERF_EN`)

## Operation
- Storage: a main register drives `out_*`; a skid register holds one more entry.
- in_fire = `in_valid & in_ready`; out_fire = `out_valid & out_ready`.
- States: EMPTY (no entry valid), ONE (main valid), TWO (main and skid valid). `out_valid` = state != EMPTY. `in_ready` = state != TWO.
- EMPTY: in_fire → ONE, main ← in.
- ONE, in_fire & out_fire → ONE, main ← in.
- ONE, in_fire & !out_fire → TWO, skid ← in.
- ONE, !in_fire & out_fire → EMPTY.
- ONE, neither → ONE, hold.
- TWO: out_fire → ONE, main ← skid. Otherwise hold. in_fire is impossible in TWO.
- Order is strictly FIFO. The skid entry never overtakes the main entry.
- `out_rd_we` = main.rd_we & `out_valid`. It is 0 whenever the state is EMPTY.
- `flush` has the highest priority over all other events in the same cycle:
  - next state is EMPTY and both valid bits clear;
  - any simultaneous in_fire is discarded;
  - payload registers may hold stale data, but `out_rd_we` is 0;
  - a simultaneous out_fire still counts as retired, because the write port already sampled it.
- Reset: state EMPTY. `out_valid`=0, `out_result`=0, `out_rd_addr`=0, `out_rd_we`=0, `in_ready`=1, `retire_cnt`=0. Skid payload is cleared to 0.
- Reset asserted mid-transfer drops all held entries immediately, without waiting for a clock edge.

## Timing
- Latency: one cycle from in_fire to `out_valid` in EMPTY.
- Throughput: one result per cycle while `out_ready` stays high.
- `in_ready` falls in the cycle after the stall that fills the skid. It rises in the cycle after out_fire from TWO.
- Maximum occupancy is 2. The first stall cycle never drops data.
- `in_ready`, `out_*` and `retire_cnt` are flop outputs. The only combinational logic is next-state and data-mux logic.

## Configuration
- `WB_STAGE_PERF_EN` defined:
  - `retire_cnt` port exists;
  - it increments by 1 on each out_fire with `out_rd_we`=1;
  - it wraps modulo 2^CNT_W;
  - it is unaffected by `flush`, except that an out_fire in the flush cycle still counts.
- `WB_STAGE_PERF_EN` undefined: the port and counter are removed, and all other behaviour is identical.

## Test plan
- Streaming: `out_ready`=1; send results 0x11, 0x22, 0x33 with rd=1,2,3 on consecutive cycles → same sequence on `out_*` one cycle later; `in_ready` stays 1.
- Backpressure: send 0xA then 0xB while `out_ready`=0 → state TWO, `in_ready`=0 next cycle. Raise `out_ready` → 0xA then 0xB in consecutive cycles, none lost or duplicated.
- Flush: hold 2 entries, assert `flush` with `in_valid`=1 and data 0xC → `out_valid`=0 and `out_rd_we`=0 next cycle; 0xC never appears.
- Async reset mid-stall: TWO state, pulse `rst` between clock edges → outputs 0 and `in_ready`=1 before the next edge.
- Counter (`WB_STAGE_PERF_EN`, CNT_W=4): retire 17 writes with rd_we=1 plus 3 with rd_we=0 → `retire_cnt`=1 after wrap.
